dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words of storage (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response valid (legal range 1..15).
REQ-003 SHALL have port clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid_i  input  1  request present.
REQ-006 SHALL have port req_ready_o  output  1  responder can accept a request.
REQ-007 SHALL have port req_write_i  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr_i  input  32  byte address.
REQ-009 SHALL have port req_wdata_i  input  32  store data.
REQ-010 SHALL have port req_be_i  input  4  byte enables, bit n covering wdata[8n+7:8n].
REQ-011 SHALL have port resp_valid_o  output  1  response present.
REQ-012 SHALL have port resp_ready_i  input  1  requester accepts the response.
REQ-013 SHALL have port resp_rdata_o  output  32  load data (0 for stores and errors).
REQ-014 SHALL have port resp_err_o  output  1  misaligned or out-of-range access.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, BUSY, RESP.
REQ-016 SHALL drive req_ready_o=1 only in IDLE; accept on a rising edge with req_valid_i && req_ready_o, latching write, addr, wdata and be.
REQ-017 SHALL, on accept, go to RESP when LATENCY=1, else go to BUSY with a down-counter loaded with LATENCY-2.
REQ-018 SHALL, in BUSY, decrement the counter each cycle and go to RESP on the cycle after it reads 0, so resp_valid_o rises exactly LATENCY cycles after the accept edge.
REQ-019 SHALL perform the memory access on the edge entering RESP: a load captures mem[idx] into resp_rdata_o; a store updates mem[idx].
REQ-020 SHALL compute idx = addr[log2(DEPTH)+1:2].
REQ-021 SHALL flag an error when addr[1:0]!=0 or addr >= 4*DEPTH; on error, set resp_err_o=1 and resp_rdata_o=0, and leave storage untouched.
REQ-022 SHALL hold resp_valid_o, resp_rdata_o and resp_err_o stable in RESP until resp_ready_i=1, then return to IDLE on that edge.
REQ-023 SHALL keep req_ready_o=0 in RESP, so a new request is accepted no earlier than the cycle after the response handshake (one outstanding transaction).
REQ-024 SHALL ignore req_valid_i outside IDLE; the requester holds the request until accepted.
REQ-025 SHALL make a load issued after a store to the same word return the stored value.

Reset
REQ-026 SHALL, while rst_i=0, force state=IDLE, counter=0, latched request fields=0, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, and req_ready_o=0.
REQ-027 SHALL drive req_ready_o=1 from the first cycle after rst_i deasserts.
REQ-028 SHALL, when reset asserts mid-transaction, abandon the transaction: a store still in BUSY is not written; storage contents are not reset.

Configuration
REQ-029 SHALL support macro DMEM_BYTE_MASK_EN: when defined, a store writes only the bytes whose req_be_i bit is 1, and req_be_i=0 is an error.
REQ-030 SHALL, when DMEM_BYTE_MASK_EN is undefined, ignore req_be_i and write all 32 bits on every store.

Verification
REQ-031 SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10 -> resp_valid_o 2 cycles after each accept, load rdata=0xDEADBEEF, err=0.
REQ-032 SHALL cover: load from 0x13 and from 4*DEPTH -> resp_err_o=1, rdata=0, memory unchanged on a later load of 0x10.
REQ-033 SHALL cover: resp_ready_i held 0 for 5 cycles -> resp_valid_o/rdata stable, req_ready_o=0 throughout, IDLE one cycle after the handshake.
REQ-034 SHALL cover: with DMEM_BYTE_MASK_EN, word 0x11223344 then store 0xAABBCCDD be=4'b0101 -> load returns 0x11BB33DD; without the macro -> 0xAABBCCDD.
REQ-035 SHALL cover: rst_i pulsed low while in BUSY on a store of 0x55 to 0x20 -> outputs reset immediately, later load of 0x20 returns the prior value.
REQ-036 SHALL cover: LATENCY=1 back-to-back requests with resp_ready_i=1 -> one accept every 2 cycles, responses in order.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed access latency
// Optional byte-masked stores are enabled by defining DMEM_BYTE_MASK_EN.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);
    localparam int          AW         = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] mem [DEPTH];

    logic          accept;
    logic          enter_resp;
    logic          acc_write;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   wmask;
    logic [31:0]   wr_word;

    assign req_ready_o = rst_i && (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;

    // With LATENCY=1 the access happens on the accept edge itself, before the latches are loaded.
    assign acc_write = (state == IDLE) ? req_write_i : write_q;
    assign acc_addr  = (state == IDLE) ? req_addr_i  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
    assign acc_be    = (state == IDLE) ? req_be_i    : be_q;
    assign acc_idx   = acc_addr[AW+1:2];

`ifdef DMEM_BYTE_MASK_EN
    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT) || (acc_be == 4'b0000);
    assign wmask   = {{8{acc_be[3]}}, {8{acc_be[2]}}, {8{acc_be[1]}}, {8{acc_be[0]}}};
`else
    logic unused_be;
    assign unused_be = ^acc_be;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
    assign wmask     = 32'hFFFF_FFFF;
`endif

    assign wr_word = (mem[acc_idx] & ~wmask) | (acc_wdata & wmask);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            be_q         <= 4'd0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'd0;
            resp_err_o   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                write_q <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
            if (enter_resp) begin
                resp_valid_o <= 1'b1;
                resp_err_o   <= acc_err;
                resp_rdata_o <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
            end else if ((state == RESP) && resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside the reset domain; enter_resp is never set while reset is held.
    always_ff @(posedge clk_i) begin
        if (enter_resp && acc_write && !acc_err) begin
            mem[acc_idx] <= wr_word;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder (LATENCY=2 main instance, LATENCY=1 back-to-back instance)
module tb_dmem_responder;
    localparam int DEPTH  = 256;
    localparam int DEPTH1 = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;
    logic        req_valid1, req_ready1, req_write1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, req_wdata1, resp_rdata1;
    logic [3:0]  req_be1;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
        .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
    );

    dmem_responder #(.DEPTH(DEPTH1), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_write_i(req_write1),
        .req_addr_i(req_addr1), .req_wdata_i(req_wdata1), .req_be_i(req_be1),
        .resp_valid_o(resp_valid1), .resp_ready_i(resp_ready1),
        .resp_rdata_o(resp_rdata1), .resp_err_o(resp_err1)
    );

    // Reference: word address = byte address / 4, error on misalignment or beyond the array.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] b, output logic [31:0] r, output logic e);
        int idx;
        logic [31:0] word;
        e = ((a % 4) != 0) || (a >= 32'(4 * DEPTH));
`ifdef DMEM_BYTE_MASK_EN
        if (b == 4'd0) e = 1'b1;
`endif
        r = 32'd0;
        if (!e) begin
            idx = int'(a / 4);
            if (w) begin
                word = model_mem[idx];
                for (int k = 0; k < 4; k++) begin
`ifdef DMEM_BYTE_MASK_EN
                    if (b[k]) word[8*k +: 8] = d[8*k +: 8];
`else
                    word[8*k +: 8] = d[8*k +: 8];
`endif
                end
                model_mem[idx] = word;
            end else begin
                r = model_mem[idx];
            end
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = b;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_asserts++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b required 1 within 50 cycles", req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 50);
        n_asserts++;
        if (!resp_valid) begin
            n_fail++;
            $display("FAIL resp_timeout: resp_valid=%0b required 1 within 50 cycles", resp_valid);
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    task automatic run(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd, output logic e,
                       output logic [31:0] exp_rd, output logic exp_e);
        issue(w, a, d, b, lat);
        rd = resp_rdata;
        e  = resp_err;
        model_access(w, a, d, b, exp_rd, exp_e);
        finish_resp();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_asserts++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%0b valid=%0b err=%0b rdata=%h required all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: req_ready=%0b required 1", req_ready);
        end
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd, er; logic e, ee;
        for (int i = 0; i < DEPTH; i++) begin
            run(1'b1, 32'(i * 4), $urandom, 4'hF, lat, rd, e, er, ee);
            n_asserts++;
            if (e !== 1'b0 || lat != 2) begin
                n_fail++;
                $display("FAIL fill_store[%0d]: err=%0b lat=%0d required err=0 lat=2", i, e, lat);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd, er; logic e, ee;
        run(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if ({lat[3:0], e, rd} !== {4'd2, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL basic_store: lat=%0d err=%0b rdata=%h required lat=2 err=0 rdata=0", lat, e, rd);
        end
        run(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if ({lat[3:0], e, rd} !== {4'd2, 1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL basic_load: lat=%0d err=%0b rdata=%h required lat=2 err=0 rdata=deadbeef", lat, e, rd);
        end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd, er; logic e, ee;
        logic [31:0] addrs [3];
        addrs[0] = 32'h13; addrs[1] = 32'(4 * DEPTH); addrs[2] = 32'h12;
        for (int i = 0; i < 3; i++) begin
            run(i == 2, addrs[i], 32'h1234_5678, 4'hF, lat, rd, e, er, ee);
            n_asserts++;
            if ({e, rd} !== {1'b1, 32'd0}) begin
                n_fail++;
                $display("FAIL err_access[%h]: err=%0b rdata=%h required err=1 rdata=0", addrs[i], e, rd);
            end
        end
        run(1'b0, 32'h10, 32'h0, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if ({e, rd} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL err_mem_unchanged: err=%0b rdata=%h required err=0 rdata=deadbeef", e, rd);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] er; logic ee;
        issue(1'b0, 32'h10, 32'h0, 4'hF, lat);
        model_access(1'b0, 32'h10, 32'h0, 4'hF, er, ee);
        for (int i = 0; i < 5; i++) begin
            n_asserts++;
            if ({resp_valid, req_ready, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'hDEADBEEF}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%0b ready=%0b err=%0b rdata=%h required 1 0 0 deadbeef",
                         i, resp_valid, req_ready, resp_err, resp_rdata);
            end
            @(negedge clk);
        end
        finish_resp();
        @(negedge clk);
        n_asserts++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release: ready=%0b valid=%0b required ready=1 valid=0", req_ready, resp_valid);
        end
    endtask

    task automatic test_byte_mask();
        int lat; logic [31:0] rd, er; logic e, ee;
        logic [31:0] exp_merge, exp_after;
        logic        exp_be0_err;
`ifdef DMEM_BYTE_MASK_EN
        exp_merge = 32'h11BB33DD; exp_after = 32'h11BB33DD; exp_be0_err = 1'b1;
`else
        exp_merge = 32'hAABBCCDD; exp_after = 32'h0; exp_be0_err = 1'b0;
`endif
        run(1'b1, 32'h40, 32'h11223344, 4'hF, lat, rd, e, er, ee);
        run(1'b1, 32'h40, 32'hAABBCCDD, 4'b0101, lat, rd, e, er, ee);
        run(1'b0, 32'h40, 32'h0, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if ({e, rd} !== {1'b0, exp_merge}) begin
            n_fail++;
            $display("FAIL byte_mask_merge: err=%0b rdata=%h required err=0 rdata=%h", e, rd, exp_merge);
        end
        run(1'b1, 32'h40, 32'h0, 4'b0000, lat, rd, e, er, ee);
        n_asserts++;
        if (e !== exp_be0_err) begin
            n_fail++;
            $display("FAIL byte_mask_be0: err=%0b required %0b", e, exp_be0_err);
        end
        run(1'b0, 32'h40, 32'h0, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if (rd !== exp_after) begin
            n_fail++;
            $display("FAIL byte_mask_after_be0: rdata=%h required %h", rd, exp_after);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd, er, prior; logic e, ee;
        prior = model_mem[32'h20 / 4];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_be = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_asserts++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== 35'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: ready=%0b valid=%0b err=%0b rdata=%h required all 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(1'b0, 32'h20, 32'h0, 4'hF, lat, rd, e, er, ee);
        n_asserts++;
        if ({e, rd} !== {1'b0, prior}) begin
            n_fail++;
            $display("FAIL midreset_mem: err=%0b rdata=%h required err=0 rdata=%h", e, rd, prior);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, er, a; logic e, ee, w; int sel, stall;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
            else if (sel == 8) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
            else               a = 32'(4 * DEPTH) - 4 + 4 * 32'($urandom_range(0, 1));
            w     = 1'($urandom_range(0, 1));
            stall = $urandom_range(0, 3);
            issue(w, a, $urandom, 4'($urandom), lat);
            repeat (stall) @(negedge clk);
            rd = resp_rdata;
            e  = resp_err;
            model_access(w, a, req_wdata, req_be, er, ee);
            finish_resp();
            n_asserts++;
            if ({lat[3:0], e, rd} !== {4'd2, ee, er}) begin
                n_fail++;
                $display("FAIL random[%0d] w=%0b a=%h: lat=%0d err=%0b rdata=%h required lat=2 err=%0b rdata=%h",
                         i, w, a, lat, e, rd, ee, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data [4];
        logic        tw [9];
        logic [31:0] ta [9];
        logic [32:0] exp_q [$];
        logic [32:0] exp;
        int acc_cyc [$];
        int cyc, nreq, nresp;
        logic acc;
        for (int i = 0; i < 4; i++) begin
            data[i] = $urandom;
            tw[i] = 1'b1; ta[i] = 32'(i * 4);
            tw[4 + i] = 1'b0; ta[4 + i] = 32'((3 - i) * 4);
        end
        tw[8] = 1'b0; ta[8] = 32'(4 * DEPTH1);
        resp_ready1 = 1'b1;
        @(negedge clk);
        nreq = 0; nresp = 0; cyc = 0;
        req_valid1 = 1'b1; req_write1 = tw[0]; req_addr1 = ta[0]; req_wdata1 = data[0]; req_be1 = 4'hF;
        while (nresp < 9 && cyc < 100) begin
            acc = req_valid1 && req_ready1;
            if (resp_valid1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
                n_asserts++;
                if ({resp_err1, resp_rdata1} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: err=%0b rdata=%h required err=%0b rdata=%h",
                             nresp, resp_err1, resp_rdata1, exp[32], exp[31:0]);
                end
                nresp++;
            end
            if (acc) begin
                acc_cyc.push_back(cyc);
                if (nreq == 8)     exp_q.push_back({1'b1, 32'd0});
                else if (tw[nreq]) exp_q.push_back({1'b0, 32'd0});
                else               exp_q.push_back({1'b0, data[3 - (nreq - 4)]});
            end
            @(posedge clk);
            #1;
            if (acc) begin
                nreq++;
                if (nreq < 9) begin
                    req_write1 = tw[nreq]; req_addr1 = ta[nreq];
                    req_wdata1 = (nreq < 4) ? data[nreq] : 32'h0;
                end else begin
                    req_valid1 = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req_valid1 = 1'b0;
        n_asserts++;
        if (nresp != 9) begin
            n_fail++;
            $display("FAIL b2b_count: responses=%0d required 9", nresp);
        end
        for (int k = 1; k < acc_cyc.size(); k++) begin
            n_asserts++;
            if (acc_cyc[k] - acc_cyc[k-1] != 2) begin
                n_fail++;
                $display("FAIL b2b_spacing[%0d]: gap=%0d required 2", k, acc_cyc[k] - acc_cyc[k-1]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; resp_ready = 1'b0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_be1 = 4'hF; resp_ready1 = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_errors();
        test_backpressure();
        test_byte_mask();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
